// File: rtl/mem_access_unit_if.sv
// Memory-side request/acknowledge port of mem_access_unit.
//   mem_req   : access request, held until ack or timeout
//   mem_we    : 1 = write, valid only while mem_req is high
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_rdata : read data, valid when mem_ack is high
//   mem_ack   : memory completes the access this cycle
// master = the access unit, slave = the memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR register pair with a req/ack memory handshake engine.
// MAR and MDR load from BusMuxOut; a one-cycle start_read/start_write pulse
// launches an access that waits for mem_ack or aborts after TIMEOUT cycles.
// Ports:
//   clock, clear              : rising-edge clock, synchronous active-high reset
//   BusMuxOut                 : datapath bus
//   MARin / MDRin             : load MAR (low ADDR_W bits) / MDR from the bus
//   start_read / start_write  : one-cycle access command
//   mem                       : memory port (master side)
//   BusMuxInMAR / BusMuxInMDR : MAR / MDR contents
//   busy                      : access in progress
//   done                      : one-cycle pulse when an access finishes or is rejected
//   error                     : sticky, last command aborted (timeout or both starts)
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              start_read,
    input  logic              start_write,
    mem_access_unit_if.master mem,
    output logic [ADDR_W-1:0] BusMuxInMAR,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit HAS_TIMEOUT = (TIMEOUT != 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_acc_addr;
    logic [DATA_W-1:0] r_acc_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_done;
    logic              r_error;

    logic              w_start_one;
    logic              w_start_both;
    logic              w_timeout;

    assign w_start_one  = start_read ^ start_write;
    assign w_start_both = start_read & start_write;
    assign w_timeout    = HAS_TIMEOUT && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; ack wins over a simultaneous timeout
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:   if (w_start_one)                  w_state_next = ACCESS;
            ACCESS: if (mem.mem_ack || w_timeout)     w_state_next = IDLE;
            default:                                  w_state_next = IDLE;
        endcase
    end

    // Datapath registers.
    // The access address/data are snapshotted at start from the pre-edge
    // MAR/MDR, so a MARin/MDRin in the start cycle loads the registers
    // without disturbing the access being launched.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_mar       <= '0;
            r_mdr       <= '0;
            r_acc_addr  <= '0;
            r_acc_wdata <= '0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) r_mdr <= BusMuxOut;
                    if (w_start_one) begin
                        r_acc_addr  <= r_mar;
                        r_acc_wdata <= r_mdr;
                        r_we        <= start_write;
                        r_error     <= 1'b0;
                        r_cnt       <= '0;
                    end else if (w_start_both) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ack) begin
                        if (!r_we) r_mdr <= mem.mem_rdata;
                        r_we   <= 1'b0;
                        r_done <= 1'b1;
                    end else if (w_timeout) begin
                        r_we    <= 1'b0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registers
    always_comb begin
        busy          = (r_state == ACCESS);
        mem.mem_req   = busy;
        mem.mem_we    = busy & r_we;
        mem.mem_addr  = busy ? r_acc_addr  : r_mar;
        mem.mem_wdata = busy ? r_acc_wdata : r_mdr;
        BusMuxInMAR   = r_mar;
        BusMuxInMDR   = r_mdr;
        done          = r_done;
        error         = r_error;
    end

endmodule
